// File: rtl/rv32i_pkg.sv
// Shared RV32I encodings: opcodes, funct3 values and
// bit positions of the one-hot opcode-class and ALU vectors.
package rv32i_pkg;

  localparam int ALU_W = 14;
  localparam int OPC_W = 11;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  localparam int OPC_RTYPE  = 0;
  localparam int OPC_ITYPE  = 1;
  localparam int OPC_LOAD   = 2;
  localparam int OPC_STORE  = 3;
  localparam int OPC_BRANCH = 4;
  localparam int OPC_JAL    = 5;
  localparam int OPC_JALR   = 6;
  localparam int OPC_LUI    = 7;
  localparam int OPC_AUIPC  = 8;
  localparam int OPC_SYSTEM = 9;
  localparam int OPC_FENCE  = 10;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;
  localparam logic [3:0] ALU_EQ   = 4'd10;
  localparam logic [3:0] ALU_NEQ  = 4'd11;
  localparam logic [3:0] ALU_GE   = 4'd12;
  localparam logic [3:0] ALU_GEU  = 4'd13;
  // Branch compares share the set-less-than lanes.
  localparam logic [3:0] ALU_LT   = ALU_SLT;
  localparam logic [3:0] ALU_LTU  = ALU_SLTU;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  function automatic logic [3:0] arith_idx(
    input logic [2:0] f3,
    input logic       alt,
    input logic       rtype
  );
    logic [3:0] r;
    r = ALU_ADD;
    unique case (f3)
      F3_ADD:  r = (alt && rtype) ? ALU_SUB : ALU_ADD;
      F3_SLL:  r = ALU_SLL;
      F3_SLT:  r = ALU_SLT;
      F3_SLTU: r = ALU_SLTU;
      F3_XOR:  r = ALU_XOR;
      F3_SR:   r = alt ? ALU_SRA : ALU_SRL;
      F3_OR:   r = ALU_OR;
      F3_AND:  r = ALU_AND;
      default: r = ALU_ADD;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] branch_idx(
    input logic [2:0] f3
  );
    logic [3:0] r;
    r = ALU_EQ;
    unique case (f3)
      F3_BEQ:  r = ALU_EQ;
      F3_BNE:  r = ALU_NEQ;
      F3_BLT:  r = ALU_LT;
      F3_BGE:  r = ALU_GE;
      F3_BLTU: r = ALU_LTU;
      F3_BGEU: r = ALU_GEU;
      default: r = ALU_EQ;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/decode_imm_gen.sv
// Immediate generator: picks the I/S/B/U/J layout from the
// opcode and sign-extends; formats without an immediate give 0.
module decode_imm_gen
  import rv32i_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic [31:0] imm_o
);

  logic [31:0] i;
  assign i = instr_i;

  always_comb begin
    imm_o = '0;
    unique case (i[6:0])
      OP_ITYPE, OP_LOAD, OP_JALR:
        imm_o = {{20{i[31]}}, i[31:20]};
      OP_STORE:
        imm_o = {{20{i[31]}}, i[31:25], i[11:7]};
      OP_BRANCH:
        imm_o = {{19{i[31]}}, i[31], i[7],
                 i[30:25], i[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        imm_o = {i[31:12], 12'b0};
      OP_JAL:
        imm_o = {{11{i[31]}}, i[31], i[19:12],
                 i[20], i[30:21], 1'b0};
      default:
        imm_o = '0;
    endcase
  end

endmodule

// File: rtl/decode.sv
// RV32I decode stage: field decoder plus the decode/execute
// pipeline register with flush/stall/bubble handling.
module decode
  import rv32i_pkg::*;
#(
  parameter int ALU_OP_W = ALU_W,
  parameter int OPCODE_W = OPC_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         fetch_instr,
  input  logic [31:0]         fetch_pc,
  input  logic                clk_en,
  output logic [31:0]         decode_pc,
  output logic [4:0]          decode_rs1_addr,
  output logic [4:0]          decode_rs2_addr,
  output logic [4:0]          decode_rd_addr,
  output logic [31:0]         decode_imm,
  output logic [2:0]          decode_funct3,
  output logic [ALU_OP_W-1:0] decode_alu_op,
  output logic [OPCODE_W-1:0] decode_opcode,
  output logic                decode_illegal,
  input  logic                stall,
  input  logic                flush,
  output logic                next_clk_en
);

  logic [6:0] op;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       alt;

  assign op  = fetch_instr[6:0];
  assign f3  = fetch_instr[14:12];
  assign f7  = fetch_instr[31:25];
  assign alt = fetch_instr[30];

  logic [31:0]         imm_d;
  logic [ALU_OP_W-1:0] alu_d;
  logic [OPCODE_W-1:0] opc_d;
  logic [4:0]          rd_d;
  logic                ill_d;
  logic                wr;
  logic                alu_v;
  logic [3:0]          alu_idx;

  decode_imm_gen u_imm (
    .instr_i (fetch_instr),
    .imm_o   (imm_d)
  );

  always_comb begin
    opc_d   = '0;
    ill_d   = 1'b0;
    wr      = 1'b1;
    alu_v   = 1'b1;
    alu_idx = ALU_ADD;
    unique case (op)
      OP_RTYPE: begin
        opc_d[OPC_RTYPE] = 1'b1;
        // Only ADD/SUB and SRL/SRA have an alternate funct7.
        ill_d = !((f7 == 7'b0000000) ||
                  (f7 == 7'b0100000 &&
                   (f3 == F3_ADD || f3 == F3_SR)));
        alu_idx = arith_idx(f3, alt, 1'b1);
      end
      OP_ITYPE: begin
        opc_d[OPC_ITYPE] = 1'b1;
        ill_d = (f3 == F3_SLL && f7 != 7'b0) ||
                (f3 == F3_SR && f7 != 7'b0 &&
                 f7 != 7'b0100000);
        alu_idx = arith_idx(f3, alt, 1'b0);
      end
      OP_LOAD: begin
        opc_d[OPC_LOAD] = 1'b1;
        ill_d = (f3 == 3'd3) || (f3 >= 3'd6);
      end
      OP_STORE: begin
        opc_d[OPC_STORE] = 1'b1;
        ill_d = (f3 >= 3'd3);
        wr    = 1'b0;
      end
      OP_BRANCH: begin
        opc_d[OPC_BRANCH] = 1'b1;
        ill_d   = (f3 == 3'd2) || (f3 == 3'd3);
        wr      = 1'b0;
        alu_idx = branch_idx(f3);
      end
      OP_JAL: opc_d[OPC_JAL] = 1'b1;
      OP_JALR: begin
        opc_d[OPC_JALR] = 1'b1;
        ill_d = (f3 != 3'd0);
      end
      OP_LUI:   opc_d[OPC_LUI] = 1'b1;
      OP_AUIPC: opc_d[OPC_AUIPC] = 1'b1;
      OP_SYSTEM: begin
        opc_d[OPC_SYSTEM] = 1'b1;
        wr    = 1'b0;
        alu_v = 1'b0;
      end
      OP_FENCE: begin
        opc_d[OPC_FENCE] = 1'b1;
        wr    = 1'b0;
        alu_v = 1'b0;
      end
      default: begin
        ill_d = 1'b1;
        alu_v = 1'b0;
      end
    endcase
    if (ill_d) begin
      opc_d = '0;
      alu_v = 1'b0;
    end
  end

  always_comb begin
    alu_d = '0;
    if (alu_v) alu_d = ALU_OP_W'(1) << alu_idx;
  end

  assign rd_d = (wr && !ill_d) ? fetch_instr[11:7] : 5'd0;

  logic [31:0]         pc_q;
  logic [4:0]          rs1_q, rs2_q, rd_q;
  logic [31:0]         imm_q;
  logic [2:0]          f3_q;
  logic [ALU_OP_W-1:0] alu_q;
  logic [OPCODE_W-1:0] opc_q;
  logic                ill_q;
  logic                vld_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q  <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
      rd_q  <= '0;
      imm_q <= '0;
      f3_q  <= '0;
      alu_q <= '0;
      opc_q <= '0;
      ill_q <= 1'b0;
      vld_q <= 1'b0;
    end else if (flush) begin
      ill_q <= 1'b0;
      vld_q <= 1'b0;
    end else if (stall) begin
      vld_q <= 1'b0;
    end else if (clk_en) begin
      pc_q  <= fetch_pc;
      rs1_q <= fetch_instr[19:15];
      rs2_q <= fetch_instr[24:20];
      rd_q  <= rd_d;
      imm_q <= imm_d;
      f3_q  <= f3;
      alu_q <= alu_d;
      opc_q <= opc_d;
      ill_q <= ill_d;
      vld_q <= 1'b1;
    end else begin
      vld_q <= 1'b0;
    end
  end

  assign decode_pc       = pc_q;
  assign decode_rs1_addr = rs1_q;
  assign decode_rs2_addr = rs2_q;
  assign decode_rd_addr  = rd_q;
  assign decode_imm      = imm_q;
  assign decode_funct3   = f3_q;
  assign decode_alu_op   = alu_q;
  assign decode_opcode   = opc_q;
  assign decode_illegal  = ill_q;
  assign next_clk_en     = vld_q;

endmodule

// File: tb/tb_decode.sv
// Randomised bench for decode against an instruction-level
// reference model, plus directed literal checks.
module tb_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fetch_instr;
  logic [31:0] fetch_pc;
  logic        clk_en;
  logic        stall;
  logic        flush;
  logic [31:0] decode_pc;
  logic [4:0]  decode_rs1_addr;
  logic [4:0]  decode_rs2_addr;
  logic [4:0]  decode_rd_addr;
  logic [31:0] decode_imm;
  logic [2:0]  decode_funct3;
  logic [13:0] decode_alu_op;
  logic [10:0] decode_opcode;
  logic        decode_illegal;
  logic        next_clk_en;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decode dut (
    .clk             (clk),
    .rst             (rst),
    .fetch_instr     (fetch_instr),
    .fetch_pc        (fetch_pc),
    .clk_en          (clk_en),
    .decode_pc       (decode_pc),
    .decode_rs1_addr (decode_rs1_addr),
    .decode_rs2_addr (decode_rs2_addr),
    .decode_rd_addr  (decode_rd_addr),
    .decode_imm      (decode_imm),
    .decode_funct3   (decode_funct3),
    .decode_alu_op   (decode_alu_op),
    .decode_opcode   (decode_opcode),
    .decode_illegal  (decode_illegal),
    .stall           (stall),
    .flush           (flush),
    .next_clk_en     (next_clk_en)
  );

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [2:0]  f3;
    logic [13:0] alu;
    logic [10:0] opc;
    logic        ill;
  } fields_t;

  // ALU lanes: ADD SUB SLL SLT SLTU XOR SRL SRA OR AND EQ NEQ GE GEU
  localparam int ARITH[8] = '{0, 2, 3, 4, 5, 6, 8, 9};
  localparam int BRIDX[8] = '{10, 11, 0, 0, 3, 12, 4, 13};

  function automatic fields_t model(input logic [31:0] i);
    fields_t r;
    logic [2:0] f3;
    logic [6:0] f7;
    int  cls;
    int  alu;
    bit  noalu;
    bit  nord;
    f3 = i[14:12];
    f7 = i[31:25];
    r = '0;
    r.rs1 = i[19:15];
    r.rs2 = i[24:20];
    r.f3  = f3;
    cls = -1;
    alu = 0;
    noalu = 0;
    nord = 0;
    case (i[6:0])
      7'h33: begin
        cls = 0;
        r.ill = !(f7 == 0 ||
                  (f7 == 7'h20 && (f3 == 0 || f3 == 5)));
        alu = ARITH[f3];
        if (i[30] && f3 == 0) alu = 1;
        if (i[30] && f3 == 5) alu = 7;
      end
      7'h13: begin
        cls = 1;
        r.imm = 32'($signed(i[31:20]));
        if (f3 == 1 && f7 != 0) r.ill = 1;
        if (f3 == 5 && !(f7 == 0 || f7 == 7'h20))
          r.ill = 1;
        alu = ARITH[f3];
        if (i[30] && f3 == 5) alu = 7;
      end
      7'h03: begin
        cls = 2;
        r.imm = 32'($signed(i[31:20]));
        r.ill = (f3 == 3 || f3 == 6 || f3 == 7);
      end
      7'h23: begin
        cls = 3;
        nord = 1;
        r.imm = 32'($signed({i[31:25], i[11:7]}));
        r.ill = (f3 > 2);
      end
      7'h63: begin
        cls = 4;
        nord = 1;
        r.imm = 32'($signed({i[31], i[7], i[30:25],
                             i[11:8], 1'b0}));
        r.ill = (f3 == 2 || f3 == 3);
        alu = BRIDX[f3];
      end
      7'h6F: begin
        cls = 5;
        r.imm = 32'($signed({i[31], i[19:12], i[20],
                             i[30:21], 1'b0}));
      end
      7'h67: begin
        cls = 6;
        r.imm = 32'($signed(i[31:20]));
        r.ill = (f3 != 0);
      end
      7'h37: begin
        cls = 7;
        r.imm = i & 32'hFFFFF000;
      end
      7'h17: begin
        cls = 8;
        r.imm = i & 32'hFFFFF000;
      end
      7'h73: begin cls = 9; nord = 1; noalu = 1; end
      7'h0F: begin cls = 10; nord = 1; noalu = 1; end
      default: begin r.ill = 1; noalu = 1; end
    endcase
    r.rd = (nord || r.ill) ? 5'd0 : i[11:7];
    if (!r.ill && cls >= 0) r.opc = 11'(1) << cls;
    if (!r.ill && !noalu) r.alu = 14'(1) << alu;
    return r;
  endfunction

  fields_t     m_f;
  logic [31:0] m_pc;
  logic        m_nce;
  logic        m_ill;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_f   <= '0;
      m_pc  <= '0;
      m_nce <= 1'b0;
      m_ill <= 1'b0;
    end else if (flush) begin
      m_nce <= 1'b0;
      m_ill <= 1'b0;
    end else if (stall) begin
      m_nce <= 1'b0;
    end else if (clk_en) begin
      m_f   <= model(fetch_instr);
      m_pc  <= fetch_pc;
      m_nce <= 1'b1;
      m_ill <= model(fetch_instr).ill;
    end else begin
      m_nce <= 1'b0;
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("next_clk_en", 32'(next_clk_en), 32'(m_nce));
    chk("illegal", 32'(decode_illegal), 32'(m_ill));
    if (m_nce) begin
      chk("pc", decode_pc, m_pc);
      chk("rs1", 32'(decode_rs1_addr), 32'(m_f.rs1));
      chk("rs2", 32'(decode_rs2_addr), 32'(m_f.rs2));
      chk("rd", 32'(decode_rd_addr), 32'(m_f.rd));
      chk("funct3", 32'(decode_funct3), 32'(m_f.f3));
      chk("opcode", 32'(decode_opcode), 32'(m_f.opc));
      if (!m_f.ill) begin
        chk("imm", decode_imm, m_f.imm);
        chk("alu_op", 32'(decode_alu_op), 32'(m_f.alu));
      end
    end
  end

  task automatic drive(input logic [31:0] ins,
                       input logic [31:0] pc,
                       input logic ce, st, fl);
    fetch_instr = ins;
    fetch_pc    = pc;
    clk_en      = ce;
    stall       = st;
    flush       = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #3;
  endtask

  task automatic all_zero(input string nm);
    chk({nm, "_pc"}, decode_pc, 32'h0);
    chk({nm, "_regs"}, {17'h0, decode_rs1_addr,
        decode_rs2_addr, decode_rd_addr}, 32'h0);
    chk({nm, "_imm"}, decode_imm, 32'h0);
    chk({nm, "_ctl"}, {decode_funct3, decode_alu_op,
        decode_opcode, decode_illegal, next_clk_en},
        32'h0);
  endtask

  function automatic logic [31:0] rnd_instr();
    localparam logic [6:0] OPS[11] = '{7'h33, 7'h13,
      7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37,
      7'h17, 7'h73, 7'h0F};
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(15) != 0) begin
      r[6:0] = OPS[$urandom_range(10)];
      case ($urandom_range(3))
        0: r[31:25] = 7'h00;
        1: r[31:25] = 7'h20;
        default: ;
      endcase
    end
    return r;
  endfunction

  initial begin
    rst = 1'b0;
    drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #3;
    all_zero("reset");
    rst = 1'b1;

    drive(32'hFFF00093, 32'h100, 1'b1, 1'b0, 1'b0);
    step();
    chk("addi_rd", 32'(decode_rd_addr), 32'd1);
    chk("addi_rs1", 32'(decode_rs1_addr), 32'd0);
    chk("addi_imm", decode_imm, 32'hFFFFFFFF);
    chk("addi_alu", 32'(decode_alu_op), 32'h1);
    chk("addi_opc", 32'(decode_opcode), 32'h2);
    chk("addi_nce", 32'(next_clk_en), 32'd1);

    drive(32'hFE208EE3, 32'h104, 1'b1, 1'b0, 1'b0);
    step();
    chk("beq_rs1", 32'(decode_rs1_addr), 32'd1);
    chk("beq_rs2", 32'(decode_rs2_addr), 32'd2);
    chk("beq_rd", 32'(decode_rd_addr), 32'd0);
    chk("beq_imm", decode_imm, 32'hFFFFFFFC);
    chk("beq_alu", 32'(decode_alu_op), 32'h400);
    chk("beq_opc", 32'(decode_opcode), 32'h10);

    drive(32'h123450B7, 32'h108, 1'b1, 1'b0, 1'b0);
    step();
    drive(32'h00000013, 32'h10C, 1'b1, 1'b1, 1'b0);
    repeat (2) begin
      step();
      chk("stall_nce", 32'(next_clk_en), 32'd0);
      chk("stall_imm", decode_imm, 32'h12345000);
      chk("stall_rd", 32'(decode_rd_addr), 32'd1);
    end
    stall = 1'b0;
    step();
    chk("nop_nce", 32'(next_clk_en), 32'd1);
    chk("nop_imm", decode_imm, 32'h0);
    chk("nop_rd", 32'(decode_rd_addr), 32'd0);
    chk("nop_opc", 32'(decode_opcode), 32'h2);

    drive(32'h00000000, 32'h110, 1'b1, 1'b0, 1'b0);
    step();
    chk("zero_ill", 32'(decode_illegal), 32'd1);
    chk("zero_rd", 32'(decode_rd_addr), 32'd0);
    chk("zero_opc", 32'(decode_opcode), 32'h0);
    drive(32'h40001033, 32'h114, 1'b1, 1'b0, 1'b0);
    step();
    chk("sll7_ill", 32'(decode_illegal), 32'd1);
    chk("sll7_rd", 32'(decode_rd_addr), 32'd0);
    chk("sll7_opc", 32'(decode_opcode), 32'h0);

    drive(32'h00000013, 32'h118, 1'b1, 1'b1, 1'b1);
    step();
    chk("flush_nce", 32'(next_clk_en), 32'd0);
    chk("flush_ill", 32'(decode_illegal), 32'd0);

    drive(32'hFFF00093, 32'h11C, 1'b1, 1'b0, 1'b0);
    step();
    stall = 1'b1;
    step();
    rst = 1'b0;
    #1;
    all_zero("async_rst");
    rst = 1'b1;

    for (int n = 0; n < 3000; n++) begin
      drive(rnd_instr(), $urandom,
            1'($urandom_range(3) != 0),
            1'($urandom_range(4) == 0),
            1'($urandom_range(9) == 0));
      step();
    end
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
